// File: rtl/rc4_key_search_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
//
// Shared definitions for the RC4 brute-force key search controller:
//   - default widths for the candidate key and the S-memory port
//   - ks_state_t  : top-level sequencer states
//   - mem_owner_t : which phase currently owns the single s_memory port
//   - owner_of_state() : maps a sequencer state onto its memory owner
//   - is_phase_state() : true for the three states that run a phase FSM
// -----------------------------------------------------------------------------
package rc4_pkg;

    localparam int KEY_W  = 24;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        KS_IDLE    = 3'd0,
        KS_INIT    = 3'd1,
        KS_SHUFFLE = 3'd2,
        KS_DECRYPT = 3'd3,
        KS_NEXT    = 3'd4,
        KS_FOUND   = 3'd5,
        KS_FAIL    = 3'd6
    } ks_state_t;

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_INIT = 2'd1,
        MEM_SHUF = 2'd2,
        MEM_DEC  = 2'd3
    } mem_owner_t;

    // Memory grant follows the state directly, so a phase sees its grant in
    // the same cycle its start strobe rises.
    function automatic mem_owner_t owner_of_state(input ks_state_t s);
        mem_owner_t o;
        case (s)
            KS_INIT:    o = MEM_INIT;
            KS_SHUFFLE: o = MEM_SHUF;
            KS_DECRYPT: o = MEM_DEC;
            default:    o = MEM_NONE;
        endcase
        return o;
    endfunction

    function automatic logic is_phase_state(input ks_state_t s);
        return (s == KS_INIT) || (s == KS_SHUFFLE) || (s == KS_DECRYPT);
    endfunction

endpackage

// File: rtl/rc4_key_search_ctrl_s_mem_port_mux.sv
// -----------------------------------------------------------------------------
// s_mem_port_mux
//
// Combinational 3:1 mux that hands the single s_memory port to the phase
// selected by sel_i. With no owner (or an unknown encoding) the port is
// write-disabled and address/data are driven to zero, so requesters without
// the grant can never disturb the memory.
//
// Ports:
//   sel_i                               owner select (mem_owner_t)
//   addr_init_i/data_init_i/wren_init_i init-phase requester
//   addr_shuf_i/data_shuf_i/wren_shuf_i shuffle-phase requester
//   addr_dec_i /data_dec_i /wren_dec_i  decrypt-phase requester
//   mem_addr_o/mem_data_o/mem_wren_o    to s_memory
// -----------------------------------------------------------------------------
module s_mem_port_mux
    import rc4_pkg::*;
#(
    parameter int ADDR_W = rc4_pkg::ADDR_W,
    parameter int DATA_W = rc4_pkg::DATA_W
) (
    input  mem_owner_t        sel_i,
    input  logic [ADDR_W-1:0] addr_init_i,
    input  logic [DATA_W-1:0] data_init_i,
    input  logic              wren_init_i,
    input  logic [ADDR_W-1:0] addr_shuf_i,
    input  logic [DATA_W-1:0] data_shuf_i,
    input  logic              wren_shuf_i,
    input  logic [ADDR_W-1:0] addr_dec_i,
    input  logic [DATA_W-1:0] data_dec_i,
    input  logic              wren_dec_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_wren_o
);

    always_comb begin
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_wren_o = 1'b0;
        case (sel_i)
            MEM_INIT: begin
                mem_addr_o = addr_init_i;
                mem_data_o = data_init_i;
                mem_wren_o = wren_init_i;
            end
            MEM_SHUF: begin
                mem_addr_o = addr_shuf_i;
                mem_data_o = data_shuf_i;
                mem_wren_o = wren_shuf_i;
            end
            MEM_DEC: begin
                mem_addr_o = addr_dec_i;
                mem_data_o = data_dec_i;
                mem_wren_o = wren_dec_i;
            end
            default: begin
                mem_addr_o = '0;
                mem_data_o = '0;
                mem_wren_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// -----------------------------------------------------------------------------
// rc4_key_search_ctrl
//
// Top-level sequencer for the RC4 brute-force key search. For every candidate
// key it runs the init, shuffle and decrypt phase FSMs in turn, granting the
// single s_memory port to whichever phase is active. A passing decrypt verdict
// stops the search with the key held; otherwise the key advances until
// KEY_END has been tried, after which the search fails.
//
// Optional feature: define KEY_SEARCH_TIMEOUT_EN to build a per-phase
// watchdog. If a phase runs TIMEOUT_CYCLES cycles without finishing, the
// search ends in FAIL with timeout=1. Without the macro no counter exists,
// timeout stays 0 and a phase may wait forever.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   start                              begin search (honoured in IDLE/FOUND/FAIL)
//   key                                current candidate key
//   start_init/finish_init             init-phase handshake
//   start_shuffle/finish_shuffle       shuffle-phase handshake
//   start_decrypt/finish_decrypt       decrypt-phase handshake
//   msg_valid                          decrypt verdict, qualified by finish_decrypt
//   addr_*/data_*/wren_* (init/shuf/dec) s_memory requesters
//   mem_addr/mem_data/mem_wren         granted s_memory port
//   busy                               search in progress
//   found/failed/timeout               sticky result flags
// -----------------------------------------------------------------------------
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int                KEY_W          = rc4_pkg::KEY_W,
    parameter int                ADDR_W         = rc4_pkg::ADDR_W,
    parameter int                DATA_W         = rc4_pkg::DATA_W,
    parameter logic [KEY_W-1:0]  KEY_START      = '0,
    parameter logic [KEY_W-1:0]  KEY_END        = 24'h3FFFFF,
    parameter int                TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [KEY_W-1:0]  key,
    output logic              start_init,
    input  logic              finish_init,
    output logic              start_shuffle,
    input  logic              finish_shuffle,
    output logic              start_decrypt,
    input  logic              finish_decrypt,
    input  logic              msg_valid,
    input  logic [ADDR_W-1:0] addr_init,
    input  logic [DATA_W-1:0] data_init,
    input  logic              wren_init,
    input  logic [ADDR_W-1:0] addr_shuf,
    input  logic [DATA_W-1:0] data_shuf,
    input  logic              wren_shuf,
    input  logic [ADDR_W-1:0] addr_dec,
    input  logic [DATA_W-1:0] data_dec,
    input  logic              wren_dec,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic              found,
    output logic              failed,
    output logic              timeout
);

    ks_state_t        state_q;
    logic [KEY_W-1:0] key_q;
    logic             found_q;
    logic             failed_q;
    logic             timeout_q;

    logic             phase_active;
    logic             phase_done;
    logic             wd_expired;

    // ------------------------------------------------------------------
    // Decodes from the state register
    // ------------------------------------------------------------------
    assign start_init    = (state_q == KS_INIT);
    assign start_shuffle = (state_q == KS_SHUFFLE);
    assign start_decrypt = (state_q == KS_DECRYPT);
    assign phase_active  = is_phase_state(state_q);
    assign busy          = phase_active || (state_q == KS_NEXT);

    // Only the finish of the phase that is currently running counts; stray
    // finishes from idle phase FSMs are masked here.
    assign phase_done = (start_init    && finish_init)    ||
                        (start_shuffle && finish_shuffle) ||
                        (start_decrypt && finish_decrypt);

    assign key     = key_q;
    assign found   = found_q;
    assign failed  = failed_q;
    assign timeout = timeout_q;

    // ------------------------------------------------------------------
    // Per-phase watchdog
    // ------------------------------------------------------------------
`ifdef KEY_SEARCH_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_cnt_q;

    // The count is held at zero outside the phases and cleared on every
    // phase exit, so each phase starts counting from zero on entry.
    always_ff @(posedge clk) begin
        if (reset || !phase_active || phase_done || wd_expired) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    // A finish in the final allowed cycle still wins over the watchdog.
    assign wd_expired = phase_active && !phase_done &&
                        (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired = 1'b0;

    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= KS_IDLE;
            key_q     <= KEY_START;
            found_q   <= 1'b0;
            failed_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                KS_IDLE, KS_FOUND, KS_FAIL: begin
                    if (start) begin
                        key_q     <= KEY_START;
                        found_q   <= 1'b0;
                        failed_q  <= 1'b0;
                        timeout_q <= 1'b0;
                        state_q   <= KS_INIT;
                    end
                end

                KS_INIT: begin
                    if (finish_init) begin
                        state_q <= KS_SHUFFLE;
                    end else if (wd_expired) begin
                        failed_q  <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= KS_FAIL;
                    end
                end

                KS_SHUFFLE: begin
                    if (finish_shuffle) begin
                        state_q <= KS_DECRYPT;
                    end else if (wd_expired) begin
                        failed_q  <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= KS_FAIL;
                    end
                end

                KS_DECRYPT: begin
                    if (finish_decrypt) begin
                        if (msg_valid) begin
                            found_q <= 1'b1;
                            state_q <= KS_FOUND;
                        end else begin
                            state_q <= KS_NEXT;
                        end
                    end else if (wd_expired) begin
                        failed_q  <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= KS_FAIL;
                    end
                end

                // One bubble per rejected key: it also guarantees start_init
                // drops for a cycle so the init FSM sees a fresh start.
                // The last key is compared before incrementing so the
                // counter never wraps past KEY_END.
                KS_NEXT: begin
                    if (key_q == KEY_END) begin
                        failed_q <= 1'b1;
                        state_q  <= KS_FAIL;
                    end else begin
                        key_q   <= key_q + KEY_W'(1);
                        state_q <= KS_INIT;
                    end
                end

                default: begin
                    state_q <= KS_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // s_memory port arbitration
    // ------------------------------------------------------------------
    s_mem_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_mux (
        .sel_i       (owner_of_state(state_q)),
        .addr_init_i (addr_init),
        .data_init_i (data_init),
        .wren_init_i (wren_init),
        .addr_shuf_i (addr_shuf),
        .data_shuf_i (data_shuf),
        .wren_shuf_i (wren_shuf),
        .addr_dec_i  (addr_dec),
        .data_dec_i  (data_dec),
        .wren_dec_i  (wren_dec),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_data),
        .mem_wren_o  (mem_wren)
    );

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rc4_key_search_ctrl
//
// Scoreboard bench for rc4_key_search_ctrl with KEY_START=0, KEY_END=3.
// Stimulus picks per-key phase latencies and a winning key (or none), and a
// reference model pushes the expected sequence of key attempts and the final
// result (flags, held key, busy duration) into queues. Stub phase FSMs and
// random memory requesters are driven by a separate process; a monitor pops
// and compares on each start_init rise and each end of search, and checks the
// memory port grant every cycle.
// -----------------------------------------------------------------------------
module tb_rc4_key_search_ctrl;

    localparam int KW  = 24;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [KW-1:0] key;
    logic          start_init, finish_init;
    logic          start_shuffle, finish_shuffle;
    logic          start_decrypt, finish_decrypt;
    logic          msg_valid;
    logic [AW-1:0] addr_init, addr_shuf, addr_dec, mem_addr;
    logic [DW-1:0] data_init, data_shuf, data_dec, mem_data;
    logic          wren_init, wren_shuf, wren_dec, mem_wren;
    logic          busy, found, failed, timeout;

    typedef struct {
        bit fnd;
        bit fl;
        bit tmo;
        int k;
        int cyc;
    } res_t;

    res_t res_q[$];
    int   key_q[$];
    int   checks = 0;
    int   errors = 0;

    int   lat [4][3];
    bit   win_en;
    int   win_key;
    bit   noise_en;
    bit   shuf_hang;

    rc4_key_search_ctrl #(
        .KEY_W          (KW),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .KEY_START      (24'd0),
        .KEY_END        (24'd3),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .key            (key),
        .start_init     (start_init),
        .finish_init    (finish_init),
        .start_shuffle  (start_shuffle),
        .finish_shuffle (finish_shuffle),
        .start_decrypt  (start_decrypt),
        .finish_decrypt (finish_decrypt),
        .msg_valid      (msg_valid),
        .addr_init      (addr_init),
        .data_init      (data_init),
        .wren_init      (wren_init),
        .addr_shuf      (addr_shuf),
        .data_shuf      (data_shuf),
        .wren_shuf      (wren_shuf),
        .addr_dec       (addr_dec),
        .data_dec       (data_dec),
        .wren_dec       (wren_dec),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_wren       (mem_wren),
        .busy           (busy),
        .found          (found),
        .failed         (failed),
        .timeout        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Stub phase FSMs and memory requesters (driven just after each edge)
    // ------------------------------------------------------------------
    initial begin
        int ci, cs, cd, kx;
        ci = 0; cs = 0; cd = 0;
        finish_init = 1'b0; finish_shuffle = 1'b0; finish_decrypt = 1'b0;
        msg_valid = 1'b0;
        addr_init = '0; data_init = '0; wren_init = 1'b0;
        addr_shuf = '0; data_shuf = '0; wren_shuf = 1'b0;
        addr_dec  = '0; data_dec  = '0; wren_dec  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ci = (start_init    === 1'b1) ? ci + 1 : 0;
            cs = (start_shuffle === 1'b1) ? cs + 1 : 0;
            cd = (start_decrypt === 1'b1) ? cd + 1 : 0;
            kx = int'(key[1:0]);
            finish_init    = start_init    ? (ci >= lat[kx][0])
                                           : (noise_en && $urandom_range(0, 3) == 0);
            finish_shuffle = start_shuffle ? (!shuf_hang && cs >= lat[kx][1])
                                           : (noise_en && $urandom_range(0, 3) == 0);
            finish_decrypt = start_decrypt ? (cd >= lat[kx][2])
                                           : (noise_en && $urandom_range(0, 3) == 0);
            msg_valid = (start_decrypt && finish_decrypt) ? (win_en && key == KW'(win_key))
                                                          : 1'($urandom_range(0, 1));
            addr_init = AW'($urandom); data_init = DW'($urandom); wren_init = 1'($urandom_range(0, 1));
            addr_shuf = AW'($urandom); data_shuf = DW'($urandom); wren_shuf = 1'($urandom_range(0, 1));
            addr_dec  = AW'($urandom); data_dec  = DW'($urandom); wren_dec  = 1'($urandom_range(0, 1));
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        bit            prev_busy, prev_si;
        int            busy_cnt, ek;
        res_t          r;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        prev_busy = 1'b0; prev_si = 1'b0; busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prev_busy = 1'b0; prev_si = 1'b0; busy_cnt = 0;
                continue;
            end

            // Memory port must follow only the phase that is running.
            ea = '0; ed = '0; ew = 1'b0;
            if (start_init) begin
                ea = addr_init; ed = data_init; ew = wren_init;
            end else if (start_shuffle) begin
                ea = addr_shuf; ed = data_shuf; ew = wren_shuf;
            end else if (start_decrypt) begin
                ea = addr_dec; ed = data_dec; ew = wren_dec;
            end
            check("mem_port", {mem_addr, mem_data, mem_wren}, {ea, ed, ew});
            check("phase_onehot_busy",
                  ($countones({start_init, start_shuffle, start_decrypt}) > 1) ||
                  ((start_init || start_shuffle || start_decrypt) && !busy), 1'b0);

            if (busy) busy_cnt++;

            if (start_init && !prev_si) begin
                $display("attempt key=%0d", key);
                if (key_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL key_attempt actual=%0d required=none", key);
                end else begin
                    ek = key_q.pop_front();
                    check("key_attempt", key, ek);
                end
            end

            if (prev_busy && !busy) begin
                $display("search end key=%0d found=%0d failed=%0d timeout=%0d cycles=%0d",
                         key, found, failed, timeout, busy_cnt);
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL search_end actual=ended required=running");
                end else begin
                    r = res_q.pop_front();
                    check("res_found",       found,    r.fnd);
                    check("res_failed",      failed,   r.fl);
                    check("res_timeout",     timeout,  r.tmo);
                    check("res_key",         key,      r.k);
                    check("res_busy_cycles", busy_cnt, r.cyc);
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
            prev_si   = start_init;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic check_reset_state();
        check("rst_start_init",    start_init,    1'b0);
        check("rst_start_shuffle", start_shuffle, 1'b0);
        check("rst_start_decrypt", start_decrypt, 1'b0);
        check("rst_busy",          busy,          1'b0);
        check("rst_found",         found,         1'b0);
        check("rst_failed",        failed,        1'b0);
        check("rst_timeout",       timeout,       1'b0);
        check("rst_mem_wren",      mem_wren,      1'b0);
        check("rst_mem_addr",      mem_addr,      0);
        check("rst_key",           key,           0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_latencies(input int fixed);
        for (int k = 0; k < 4; k++)
            for (int p = 0; p < 3; p++)
                lat[k][p] = (fixed > 0) ? fixed : $urandom_range(1, 4);
    endtask

    // Waits for the scoreboard to drain; random start pulses while busy
    // must be ignored by the controller.
    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (res_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
            start = noise_en && busy && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        check("search_done_in_budget", res_q.size(), 0);
        check("all_keys_tried",        key_q.size(), 0);
        res_q.delete();
        key_q.delete();
    endtask

    // Reference model: keys 0..last are each tried once; every rejected key
    // costs one extra cycle, and exhausting the range rejects all four.
    task automatic run_search(input bit w_en, input int w, input bit noise, input int fixed);
        res_t r;
        int   last, cyc;
        set_latencies(fixed);
        last = w_en ? w : 3;
        cyc  = 0;
        for (int k = 0; k <= last; k++) begin
            cyc += lat[k][0] + lat[k][1] + lat[k][2];
            key_q.push_back(k);
        end
        cyc += w_en ? last : 4;
        r.fnd = w_en; r.fl = !w_en; r.tmo = 1'b0; r.k = last; r.cyc = cyc;
        res_q.push_back(r);
        win_en = w_en; win_key = w; noise_en = noise;
        pulse_start();
        wait_done(2000);
        noise_en = 1'b0;
        repeat (3) @(negedge clk);
        check("sticky_found",  found,  w_en);
        check("sticky_failed", failed, !w_en);
        check("held_key",      key,    last);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int   n, w;
        bit   we, nz;
        res_t r;
        reset = 1'b1; start = 1'b0;
        win_en = 1'b0; win_key = 0; noise_en = 1'b0; shuf_hang = 1'b0;
        set_latencies(3);
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        @(negedge clk);

        run_search(1'b1, 0, 1'b0, 3);   // 3+3+3 busy cycles, found on key 0
        run_search(1'b0, 0, 1'b0, 2);   // range exhausted, key stays at 3
        run_search(1'b1, 2, 1'b0, 0);   // passes only on key 2
        for (int i = 0; i < 24; i++) begin
            we = ($urandom_range(0, 4) != 0);
            w  = $urandom_range(0, 3);
            nz = 1'($urandom_range(0, 1));
            run_search(we, w, nz, 0);
        end

        // Reset while the shuffle phase is running, then restart.
        set_latencies(0);
        lat[0][1] = 4;
        key_q.push_back(0);
        win_en = 1'b1; win_key = 3;
        pulse_start();
        n = 0;
        while (!start_shuffle && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_shuffle", start_shuffle, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        check("attempts_before_reset", key_q.size(), 0);
        key_q.delete();
        run_search(1'b1, 1, 1'b0, 0);

        // Shuffle phase that never finishes.
        set_latencies(0);
        shuf_hang = 1'b1;
        win_en = 1'b0;
        key_q.push_back(0);
`ifdef KEY_SEARCH_TIMEOUT_EN
        r.fnd = 1'b0; r.fl = 1'b1; r.tmo = 1'b1; r.k = 0; r.cyc = lat[0][0] + TMO;
        res_q.push_back(r);
        pulse_start();
        wait_done(500);
        check("timeout_flag",   timeout, 1'b1);
        check("timeout_failed", failed,  1'b1);
`else
        r.fnd = 1'b0;
        pulse_start();
        repeat (TMO + 24) @(negedge clk);
        check("hang_in_shuffle", start_shuffle, 1'b1);
        check("hang_busy",       busy,          1'b1);
        check("hang_no_fail",    failed,        r.fnd);
        check("hang_no_timeout", timeout,       1'b0);
        check("hang_key",        key,           0);
        check("hang_attempts",   key_q.size(),  0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        key_q.delete();
`endif
        shuf_hang = 1'b0;
        @(negedge clk);
        run_search(1'b1, 3, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
